// File: rtl/timer_entry_buffer_if.sv
// Key/commit inputs and buffered-time outputs between the keypad path and the countdown timer.
interface timer_entry_buffer_if;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        clear_entry;
    logic        commit;
    logic        busy;
    logic [15:0] digits;
    logic        loadn;
    logic [2:0]  entry_count;
    logic        overflow;
    logic        invalid_time;

    modport master (
        output key_valid, key_code, clear_entry, commit, busy,
        input  digits, loadn, entry_count, overflow, invalid_time
    );

    modport slave (
        input  key_valid, key_code, clear_entry, commit, busy,
        output digits, loadn, entry_count, overflow, invalid_time
    );
endinterface

// File: rtl/timer_entry_buffer.sv
// Four-digit MM:SS entry buffer: shifts in BCD keys, validates on START and
// strobes an active-low load to the countdown timer, then holds while it runs.
module timer_entry_buffer #(
    parameter int unsigned DIGITS       = 4,
    parameter int unsigned SEC_TENS_MAX = 5
) (
    input  logic                  clock,
    input  logic                  clearn,
    timer_entry_buffer_if.slave   bus
);

    localparam int unsigned DW = 4 * DIGITS;
    localparam int unsigned CW = 3;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_ENTRY    = 3'd1;
    localparam logic [2:0] ST_LOAD     = 3'd2;
    localparam logic [2:0] ST_WAIT_ACK = 3'd3;
    localparam logic [2:0] ST_RUN      = 3'd4;

    logic [2:0]    state_q, state_d;
    logic [DW-1:0] digits_q, digits_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          invalid_q, invalid_d;
    logic          loadn_q, loadn_d;

    logic          key_legal;
    logic          buf_full;
    logic          sec_tens_ok;

    assign key_legal   = bus.key_valid && (bus.key_code <= 4'd9);
    assign buf_full    = (count_q == CW'(DIGITS));
    assign sec_tens_ok = (digits_q[7:4] <= 4'(SEC_TENS_MAX));

    always_ff @(posedge clock or negedge clearn) begin
        if (!clearn) begin
            state_q    <= ST_IDLE;
            digits_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            invalid_q  <= 1'b0;
            loadn_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            digits_q   <= digits_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            invalid_q  <= invalid_d;
            loadn_q    <= loadn_d;
        end
    end

    // Next-state and registered-output computation; loadn_d is low only on entry to LOAD.
    always_comb begin
        state_d    = state_q;
        digits_d   = digits_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        invalid_d  = 1'b0;
        loadn_d    = 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (bus.clear_entry) begin
                    digits_d   = '0;
                    count_d    = '0;
                    overflow_d = 1'b0;
                end else if (key_legal) begin
                    digits_d = {digits_q[DW-5:0], bus.key_code};
                    count_d  = count_q + CW'(1);
                    state_d  = ST_ENTRY;
                end
            end

            ST_ENTRY: begin
                if (bus.clear_entry) begin
                    digits_d   = '0;
                    count_d    = '0;
                    overflow_d = 1'b0;
                    state_d    = ST_IDLE;
                end else if (bus.commit) begin
                    // A key arriving with the commit is dropped; check uses the pre-key buffer.
                    if (sec_tens_ok) begin
                        state_d = ST_LOAD;
                        loadn_d = 1'b0;
                    end else begin
                        invalid_d = 1'b1;
                    end
                end else if (key_legal) begin
                    if (buf_full) begin
                        overflow_d = 1'b1;
                    end else begin
                        digits_d = {digits_q[DW-5:0], bus.key_code};
                        count_d  = count_q + CW'(1);
                    end
                end
            end

            ST_LOAD: begin
                state_d = ST_WAIT_ACK;
            end

            ST_WAIT_ACK: begin
                if (bus.busy) begin
                    state_d = ST_RUN;
                end
            end

            ST_RUN: begin
                if (!bus.busy) begin
                    digits_d   = '0;
                    count_d    = '0;
                    overflow_d = 1'b0;
                    state_d    = ST_IDLE;
                end
            end

            default: begin
                state_d    = ST_IDLE;
                digits_d   = '0;
                count_d    = '0;
                overflow_d = 1'b0;
            end
        endcase
    end

    assign bus.digits       = 16'(digits_q);
    assign bus.loadn        = loadn_q;
    assign bus.entry_count  = count_q;
    assign bus.overflow     = overflow_q;
    assign bus.invalid_time = invalid_q;

endmodule

// File: tb/tb_timer_entry_buffer.sv
// Directed-vector bench for timer_entry_buffer with hand-computed expectations.
module tb_timer_entry_buffer;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    timer_entry_buffer_if tebi ();

    timer_entry_buffer #(
        .DIGITS       (4),
        .SEC_TENS_MAX (5)
    ) dut (
        .clock  (clk),
        .clearn (rst_n),
        .bus    (tebi.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic press(input logic [3:0] k);
        @(negedge clk);
        tebi.key_valid = 1'b1;
        tebi.key_code  = k;
        @(negedge clk);
        tebi.key_valid = 1'b0;
        tebi.key_code  = 4'd0;
    endtask

    task automatic pulse_commit();
        @(negedge clk);
        tebi.commit = 1'b1;
        @(negedge clk);
        tebi.commit = 1'b0;
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        tebi.clear_entry = 1'b1;
        @(negedge clk);
        tebi.clear_entry = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n            = 1'b0;
        tebi.key_valid   = 1'b0;
        tebi.key_code    = 4'd0;
        tebi.clear_entry = 1'b0;
        tebi.commit      = 1'b0;
        tebi.busy        = 1'b0;

        #23;
        check("rst_digits",  32'(tebi.digits), 32'h0);
        check("rst_loadn",   32'(tebi.loadn), 32'h1);
        check("rst_count",   32'(tebi.entry_count), 32'h0);
        check("rst_ovf",     32'(tebi.overflow), 32'h0);
        check("rst_invalid", 32'(tebi.invalid_time), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Entry 1,3,0 then commit; asynchronous reset mid-LOAD
        press(4'd1);
        check("e1_count", 32'(tebi.entry_count), 32'h1);
        press(4'd3);
        press(4'd0);
        check("e130_digits", 32'(tebi.digits), 32'h0130);
        check("e130_count",  32'(tebi.entry_count), 32'h3);
        pulse_commit();
        check("e130_loadn_low", 32'(tebi.loadn), 32'h0);
        #1 rst_n = 1'b0;
        #1;
        check("async_loadn",  32'(tebi.loadn), 32'h1);
        check("async_digits", 32'(tebi.digits), 32'h0);
        check("async_count",  32'(tebi.entry_count), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Overflow then clear
        press(4'd1); press(4'd2); press(4'd3); press(4'd4); press(4'd5);
        check("ovf_digits", 32'(tebi.digits), 32'h1234);
        check("ovf_count",  32'(tebi.entry_count), 32'h4);
        check("ovf_flag",   32'(tebi.overflow), 32'h1);
        check("ovf_loadn",  32'(tebi.loadn), 32'h1);
        pulse_clear();
        check("clr_digits", 32'(tebi.digits), 32'h0);
        check("clr_ovf",    32'(tebi.overflow), 32'h0);
        check("clr_count",  32'(tebi.entry_count), 32'h0);

        // Invalid time 01:75
        press(4'd1); press(4'd7); press(4'd5);
        pulse_commit();
        check("inv_pulse",  32'(tebi.invalid_time), 32'h1);
        check("inv_loadn",  32'(tebi.loadn), 32'h1);
        check("inv_digits", 32'(tebi.digits), 32'h0175);
        @(negedge clk);
        check("inv_pulse_end", 32'(tebi.invalid_time), 32'h0);
        check("inv_loadn2",    32'(tebi.loadn), 32'h1);
        press(4'd2);
        check("inv_still_entry", 32'(tebi.digits), 32'h1752);
        check("inv_count4",      32'(tebi.entry_count), 32'h4);
        pulse_clear();

        // Handshake 0:45
        press(4'd4); press(4'd5);
        check("hs_digits", 32'(tebi.digits), 32'h0045);
        pulse_commit();
        check("hs_loadn_low", 32'(tebi.loadn), 32'h0);
        @(negedge clk);
        check("hs_loadn_high", 32'(tebi.loadn), 32'h1);
        tebi.busy = 1'b1;
        @(negedge clk);
        press(4'd9);
        check("hs_hold_digits", 32'(tebi.digits), 32'h0045);
        check("hs_hold_count",  32'(tebi.entry_count), 32'h2);
        check("hs_hold_loadn",  32'(tebi.loadn), 32'h1);
        tebi.busy = 1'b0;
        @(negedge clk);
        check("hs_done_digits", 32'(tebi.digits), 32'h0);
        check("hs_done_count",  32'(tebi.entry_count), 32'h0);

        // Commit together with key 7 on buffer 0:12
        press(4'd1); press(4'd2);
        @(negedge clk);
        tebi.commit    = 1'b1;
        tebi.key_valid = 1'b1;
        tebi.key_code  = 4'd7;
        @(negedge clk);
        tebi.commit    = 1'b0;
        tebi.key_valid = 1'b0;
        tebi.key_code  = 4'd0;
        check("sim_loadn_low", 32'(tebi.loadn), 32'h0);
        check("sim_digits",    32'(tebi.digits), 32'h0012);
        @(negedge clk);
        check("sim_loadn_high", 32'(tebi.loadn), 32'h1);
        tebi.busy = 1'b1;
        @(negedge clk);
        tebi.busy = 1'b0;
        @(negedge clk);
        check("sim_idle_digits", 32'(tebi.digits), 32'h0);

        // Illegal key code is filtered
        press(4'd3);
        press(4'd12);
        check("filt_digits", 32'(tebi.digits), 32'h0003);
        check("filt_count",  32'(tebi.entry_count), 32'h1);
        check("filt_ovf",    32'(tebi.overflow), 32'h0);

        // Busy already high when LOAD completes
        tebi.busy = 1'b1;
        pulse_commit();
        check("bh_loadn_low", 32'(tebi.loadn), 32'h0);
        @(negedge clk);
        @(negedge clk);
        tebi.busy = 1'b0;
        @(negedge clk);
        check("bh_idle_digits", 32'(tebi.digits), 32'h0);
        check("bh_idle_count",  32'(tebi.entry_count), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
